// File: rtl/tcm_dec_tmu_sched_if.sv
// Bus bundle between the TMU slot scheduler and its neighbours
// (metric front end, shared ACS tree, path-metric stage).
interface tcm_dec_tmu_sched_if #(
  parameter int unsigned pGRP_NUM = 4,
  parameter int unsigned pBM_W    = 10
);
  localparam int unsigned GRP_W = $clog2(pGRP_NUM);

  logic                      istep_val;
  logic                      ostep_rdy;
  logic                      otree_val;
  logic [GRP_W-1:0]          ogrp;
  logic                      itree_val;
  logic [pBM_W-1:0]          itree_bm;
  logic                      itree_idx;
  logic                      obm_val;
  logic                      ibm_rdy;
  logic [pGRP_NUM*pBM_W-1:0] obm;
  logic [pGRP_NUM-1:0]       oidx;
  logic                      oerr;

  // Scheduler side
  modport master (
    input  istep_val, itree_val, itree_bm, itree_idx, ibm_rdy,
    output ostep_rdy, otree_val, ogrp, obm_val, obm, oidx, oerr
  );

  // Environment side
  modport slave (
    output istep_val, itree_val, itree_bm, itree_idx, ibm_rdy,
    input  ostep_rdy, otree_val, ogrp, obm_val, obm, oidx, oerr
  );
endinterface

// File: rtl/tcm_dec_tmu_sched.sv
// Sequencer for the shared TMU add-compare-select tree: issues one slot per
// branch group, gathers the in-order tree results into a step-wide vector and
// hands it to the path-metric stage through a valid/ready output register.
module tcm_dec_tmu_sched #(
  parameter int unsigned pGRP_NUM  = 4,
  parameter int unsigned pBM_W     = 10,
  parameter int unsigned pTREE_LAT = 3
) (
  input  logic                iclk,
  input  logic                ireset,
  input  logic                iclkena,
  tcm_dec_tmu_sched_if.master bus
);
  localparam int unsigned GRP_W = $clog2(pGRP_NUM);
  localparam int unsigned CNT_W = GRP_W + 1;
  localparam int unsigned VEC_W = pGRP_NUM * pBM_W;

  // Parameter sanity at elaboration
  if (pGRP_NUM < 2 || pGRP_NUM > 16 || (pGRP_NUM & (pGRP_NUM - 1)) != 0) begin : g_grp_chk
    $error("pGRP_NUM must be a power of 2 in 2..16");
  end
  if (pTREE_LAT < 1) begin : g_lat_chk
    $error("pTREE_LAT must be at least one enabled cycle");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_XFER
  } state_t;

  state_t               state_q,     state_d;
  logic                 step_rdy_q,  step_rdy_d;
  logic                 tree_val_q,  tree_val_d;
  logic [GRP_W-1:0]     issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]     ret_cnt_q,   ret_cnt_d;
  logic [VEC_W-1:0]     coll_bm_q,   coll_bm_d;
  logic [pGRP_NUM-1:0]  coll_idx_q,  coll_idx_d;
  logic [VEC_W-1:0]     obm_q,       obm_d;
  logic [pGRP_NUM-1:0]  oidx_q,      oidx_d;
  logic                 obm_val_q,   obm_val_d;
  logic                 oerr_q,      oerr_d;

  logic ret_full;
  logic ret_take;

  // Next-state, collection and output-register update
  always_comb begin
    state_d     = state_q;
    tree_val_d  = tree_val_q;
    issue_cnt_d = issue_cnt_q;
    ret_cnt_d   = ret_cnt_q;
    coll_bm_d   = coll_bm_q;
    coll_idx_d  = coll_idx_q;
    obm_d       = obm_q;
    oidx_d      = oidx_q;
    obm_val_d   = obm_val_q;
    oerr_d      = oerr_q;

    // Results are only legal while a step is in flight and not yet complete
    ret_full = (ret_cnt_q == CNT_W'(pGRP_NUM));
    ret_take = bus.itree_val && !ret_full &&
               ((state_q == ST_ISSUE) || (state_q == ST_DRAIN));

    if (bus.itree_val && !ret_take) begin
      oerr_d = 1'b1;
    end

    if (ret_take) begin
      for (int unsigned g = 0; g < pGRP_NUM; g++) begin
        if (ret_cnt_q[GRP_W-1:0] == GRP_W'(g)) begin
          coll_bm_d[g*pBM_W +: pBM_W] = bus.itree_bm;
          coll_idx_d[g]               = bus.itree_idx;
        end
      end
      ret_cnt_d = ret_cnt_q + CNT_W'(1);
    end

    // Downstream pop; a same-cycle transfer below re-asserts valid
    if (obm_val_q && bus.ibm_rdy) begin
      obm_val_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.istep_val) begin
          state_d     = ST_ISSUE;
          tree_val_d  = 1'b1;
          issue_cnt_d = '0;
        end
      end
      ST_ISSUE: begin
        // Power-of-2 group count lets the slot counter wrap back to 0
        issue_cnt_d = issue_cnt_q + GRP_W'(1);
        if (issue_cnt_q == GRP_W'(pGRP_NUM - 1)) begin
          tree_val_d = 1'b0;
          state_d    = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Leave as the last result lands so XFER can move it next cycle
        if (ret_cnt_d == CNT_W'(pGRP_NUM)) begin
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (!obm_val_q || bus.ibm_rdy) begin
          obm_d     = coll_bm_q;
          oidx_d    = coll_idx_q;
          obm_val_d = 1'b1;
          ret_cnt_d = '0;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign step_rdy_d = (state_d == ST_IDLE);

  // State register, frozen while the clock enable is low
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state_q     <= ST_IDLE;
      step_rdy_q  <= 1'b1;
      tree_val_q  <= 1'b0;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      coll_bm_q   <= '0;
      coll_idx_q  <= '0;
      obm_q       <= '0;
      oidx_q      <= '0;
      obm_val_q   <= 1'b0;
      oerr_q      <= 1'b0;
    end else if (iclkena) begin
      state_q     <= state_d;
      step_rdy_q  <= step_rdy_d;
      tree_val_q  <= tree_val_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      coll_bm_q   <= coll_bm_d;
      coll_idx_q  <= coll_idx_d;
      obm_q       <= obm_d;
      oidx_q      <= oidx_d;
      obm_val_q   <= obm_val_d;
      oerr_q      <= oerr_d;
    end
  end

  assign bus.ostep_rdy = step_rdy_q;
  assign bus.otree_val = tree_val_q;
  assign bus.ogrp      = issue_cnt_q;
  assign bus.obm_val   = obm_val_q;
  assign bus.obm       = obm_q;
  assign bus.oidx      = oidx_q;
  assign bus.oerr      = oerr_q;
endmodule

// File: tb/tb_tcm_dec_tmu_sched.sv
// Directed bench for tcm_dec_tmu_sched with a behavioural TMU tree and a
// scoreboard of expected step vectors.
module tb_tcm_dec_tmu_sched;
  localparam int unsigned N  = 4;
  localparam int unsigned BW = 10;
  localparam int unsigned L  = 3;

  typedef struct packed {
    logic [N-1:0]    idx;
    logic [N*BW-1:0] bm;
  } exp_t;

  logic iclk    = 1'b0;
  logic ireset  = 1'b0;
  logic iclkena = 1'b0;

  tcm_dec_tmu_sched_if #(.pGRP_NUM(N), .pBM_W(BW)) bus ();

  tcm_dec_tmu_sched #(.pGRP_NUM(N), .pBM_W(BW), .pTREE_LAT(L)) dut (
    .iclk    (iclk),
    .ireset  (ireset),
    .iclkena (iclkena),
    .bus     (bus)
  );

  always #5 iclk = ~iclk;

  // Behavioural tree: bm = 10*g + 1 + ofs, idx = g[0] ^ ofs[0], L enabled cycles
  int           bm_ofs = 0;
  logic         inj    = 1'b0;
  logic [L-1:0] pv     = '0;
  logic [BW-1:0] pbm  [L] = '{default: '0};
  logic          pidx [L] = '{default: 1'b0};

  always @(posedge iclk) begin
    if (iclkena) begin
      pv      <= {pv[L-2:0], bus.otree_val};
      pbm[0]  <= 10'(10 * int'(bus.ogrp) + 1 + bm_ofs);
      pidx[0] <= bus.ogrp[0] ^ bm_ofs[0];
      for (int s = 1; s < L; s++) begin
        pbm[s]  <= pbm[s-1];
        pidx[s] <= pidx[s-1];
      end
    end
  end

  assign bus.itree_val = pv[L-1] | inj;
  assign bus.itree_bm  = pbm[L-1];
  assign bus.itree_idx = pidx[L-1];

  int   n_run = 0;
  int   n_fail = 0;
  exp_t exp_q [$];
  int   acc_q [$];
  int   en_cnt = 0;
  int   last_acc = 0;
  int   n_acc = 0;
  int   n_rise = 0;
  int   high_cnt = 0;
  logic prev_val = 1'b0;
  logic hold_pend = 1'b0;
  logic [N+N*BW-1:0] hold_val = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk_exp(input int ofs);
    exp_t e;
    for (int g = 0; g < N; g++) begin
      e.bm[g*BW +: BW] = 10'(10 * g + 1 + ofs);
      e.idx[g]         = g[0] ^ ofs[0];
    end
    return e;
  endfunction

  // Observe outputs at the falling edge; record the upcoming edge's handshakes
  task automatic monitor();
    exp_t e;
    if (ireset) begin
      hold_pend = 1'b0;
      prev_val  = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("hold", 64'({bus.obm_val, bus.oidx, bus.obm}), 64'({1'b1, hold_val}));
      end
      if (bus.obm_val && !prev_val) n_rise++;
      if (bus.obm_val) high_cnt++;
      prev_val = bus.obm_val;
      if (iclkena && bus.istep_val && bus.ostep_rdy) begin
        exp_q.push_back(mk_exp(bm_ofs));
        last_acc = en_cnt + 1;
        acc_q.push_back(last_acc);
        n_acc++;
      end
      if (iclkena && bus.obm_val && bus.ibm_rdy) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected", 64'(bus.obm_val), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("sb_bm", 64'(bus.obm), 64'(e.bm));
          chk("sb_idx", 64'(bus.oidx), 64'(e.idx));
        end
      end
      hold_pend = bus.obm_val && !(iclkena && bus.ibm_rdy);
      hold_val  = {bus.oidx, bus.obm};
    end
    if (iclkena) en_cnt++;
  endtask

  task automatic tick();
    @(negedge iclk);
    monitor();
    @(posedge iclk);
    #1;
  endtask

  task automatic step_pulse(input string tag);
    int k  = 0;
    int a0 = n_acc;
    bus.istep_val = 1'b1;
    while (n_acc == a0 && k < 40) begin
      tick();
      k++;
    end
    bus.istep_val = 1'b0;
    chk(tag, 64'(n_acc - a0), 64'(1));
  endtask

  task automatic wait_obm(input string tag, input int budget);
    int k = 0;
    while (!bus.obm_val && k < budget) begin
      tick();
      k++;
    end
    chk(tag, 64'(bus.obm_val), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N*BW-1:0] v0, v5, v7;
    int k;
    v0 = {10'd31, 10'd21, 10'd11, 10'd1};
    v5 = {10'd36, 10'd26, 10'd16, 10'd6};
    v7 = {10'd38, 10'd28, 10'd18, 10'd8};

    bus.istep_val = 1'b0;
    bus.ibm_rdy   = 1'b1;
    ireset        = 1'b1;
    iclkena       = 1'b1;
    repeat (3) tick();
    chk("rst_rdy",  64'(bus.ostep_rdy), 64'(1));
    chk("rst_tval", 64'(bus.otree_val), 64'(0));
    chk("rst_val",  64'(bus.obm_val),   64'(0));
    chk("rst_bm",   64'(bus.obm),       64'(0));
    chk("rst_idx",  64'(bus.oidx),      64'(0));
    chk("rst_err",  64'(bus.oerr),      64'(0));
    ireset = 1'b0;
    tick();

    // 1: single step, default tree pattern
    bm_ofs = 0;
    step_pulse("t1_acc");
    for (int g = 0; g < N; g++) begin
      chk("t1_tval", 64'(bus.otree_val), 64'(1));
      chk("t1_grp",  64'(bus.ogrp),      64'(g));
      chk("t1_rdy",  64'(bus.ostep_rdy), 64'(0));
      tick();
    end
    chk("t1_tval_off", 64'(bus.otree_val), 64'(0));
    wait_obm("t1_val", 20);
    chk("t1_lat", 64'(en_cnt - last_acc), 64'(N + L + 1));
    chk("t1_bm",  64'(bus.obm),  64'(v0));
    chk("t1_idx", 64'(bus.oidx), 64'(4'b1010));
    chk("t1_err", 64'(bus.oerr), 64'(0));
    tick();
    chk("t1_pulse", 64'(bus.obm_val), 64'(0));

    // 2: back-pressure, pop and load in the same cycle
    bus.ibm_rdy = 1'b0;
    bm_ofs = 0;
    step_pulse("t2_accA");
    wait_obm("t2_valA", 20);
    bm_ofs = 5;
    step_pulse("t2_accB");
    repeat (12) tick();
    chk("t2_rdy",  64'(bus.ostep_rdy), 64'(0));
    chk("t2_val",  64'(bus.obm_val),   64'(1));
    chk("t2_bmA",  64'(bus.obm),       64'(v0));
    bus.ibm_rdy = 1'b1;
    tick();
    chk("t2_valB", 64'(bus.obm_val),   64'(1));
    chk("t2_bmB",  64'(bus.obm),       64'(v5));
    chk("t2_idxB", 64'(bus.oidx),      64'(4'b0101));
    chk("t2_rdyB", 64'(bus.ostep_rdy), 64'(1));
    tick();
    chk("t2_done", 64'(bus.obm_val), 64'(0));

    // 3: clock enable toggling through a step
    bm_ofs = 0;
    bus.ibm_rdy = 1'b0;
    step_pulse("t3_acc");
    for (int g = 0; g < N; g++) begin
      chk("t3_grp", 64'({bus.otree_val, bus.ogrp}), 64'({1'b1, 2'(g)}));
      iclkena = 1'b0;
      tick();
      chk("t3_grp_hold", 64'({bus.otree_val, bus.ogrp}), 64'({1'b1, 2'(g)}));
      iclkena = 1'b1;
      tick();
    end
    chk("t3_tval_off", 64'(bus.otree_val), 64'(0));
    k = 0;
    while (!bus.obm_val && k < 40) begin
      iclkena = ~iclkena;
      tick();
      k++;
    end
    chk("t3_val", 64'(bus.obm_val), 64'(1));
    chk("t3_bm",  64'(bus.obm),     64'(v0));
    chk("t3_idx", 64'(bus.oidx),    64'(4'b1010));
    chk("t3_err", 64'(bus.oerr),    64'(0));
    iclkena = 1'b1;
    bus.ibm_rdy = 1'b1;
    tick();
    chk("t3_done", 64'(bus.obm_val), 64'(0));

    // 4: spurious tree result while idle
    inj = 1'b1;
    tick();
    inj = 1'b0;
    chk("t4_err",  64'(bus.oerr), 64'(1));
    chk("t4_bm",   64'(bus.obm),  64'(v0));
    chk("t4_idx",  64'(bus.oidx), 64'(4'b1010));
    repeat (3) tick();
    chk("t4_sticky", 64'(bus.oerr), 64'(1));
    bm_ofs = 7;
    step_pulse("t4_acc");
    wait_obm("t4_val", 20);
    chk("t4_bm2",  64'(bus.obm),  64'(v7));
    chk("t4_idx2", 64'(bus.oidx), 64'(4'b0101));
    chk("t4_err2", 64'(bus.oerr), 64'(1));
    tick();

    // 5: reset in the middle of issue
    bm_ofs = 0;
    step_pulse("t5_acc");
    tick();
    tick();
    chk("t5_grp2", 64'({bus.otree_val, bus.ogrp}), 64'({1'b1, 2'd2}));
    ireset = 1'b1;
    #1;
    chk("t5_tval", 64'(bus.otree_val), 64'(0));
    chk("t5_grp",  64'(bus.ogrp),      64'(0));
    chk("t5_val",  64'(bus.obm_val),   64'(0));
    chk("t5_rdy",  64'(bus.ostep_rdy), 64'(1));
    chk("t5_err",  64'(bus.oerr),      64'(0));
    chk("t5_bm",   64'(bus.obm),       64'(0));
    exp_q.delete();
    tick();
    ireset = 1'b0;
    chk("t5_rdy_rel", 64'(bus.ostep_rdy), 64'(1));
    repeat (4) tick();
    chk("t5_late_err", 64'(bus.oerr),    64'(1));
    chk("t5_no_val",   64'(bus.obm_val), 64'(0));

    // 6: back-to-back steps, full throughput
    acc_q.delete();
    n_rise   = 0;
    high_cnt = 0;
    bus.ibm_rdy   = 1'b1;
    bus.istep_val = 1'b1;
    k = 0;
    while (acc_q.size() < 4 && k < 80) begin
      tick();
      k++;
    end
    bus.istep_val = 1'b0;
    chk("t6_nacc", 64'(acc_q.size()), 64'(4));
    for (int i = 1; i < acc_q.size(); i++) begin
      chk("t6_space", 64'(acc_q[i] - acc_q[i-1]), 64'(N + L + 2));
    end
    k = 0;
    while (exp_q.size() != 0 && k < 40) begin
      tick();
      k++;
    end
    repeat (2) tick();
    chk("t6_drain", 64'(exp_q.size()), 64'(0));
    chk("t6_rise",  64'(n_rise),       64'(4));
    chk("t6_pulse", 64'(high_cnt),     64'(4));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/tcm_dec_tmu_sched.md
Name: tcm_dec_tmu_sched

Overview:
- Sequencing controller for a single shared 2-metric-per-group TMU add-compare-select tree in the 4D-8PSK TCM decoder.
- Accepts one trellis step request from the metric front end and issues pGRP_NUM branch-group slots to the tree on consecutive enabled cycles, each with a group address.
- Collects the tree's per-group best metric and selected-pair index into a step-wide vector, then hands the vector to the ACS/path-metric stage through a valid/ready output register.

Parameters:
pGRP_NUM, 4, branch groups per trellis step; power of 2, range 2..16
pBM_W, 10, branch metric width; equals the tree's trel_bm_t width
pTREE_LAT, 3, tree latency in enabled cycles from slot valid to result valid

Ports:
iclk  in  1  clock
ireset  in  1  asynchronous reset, active high
iclkena  in  1  clock enable; all state frozen when low
istep_val  in  1  step request valid
ostep_rdy  out  1  step request accepted when istep_val & ostep_rdy & iclkena
otree_val  out  1  slot valid to tree ival
ogrp  out  clog2(pGRP_NUM)  group address of current slot; muxes isymb_m pair into tree
itree_val  in  1  tree oval
itree_bm  in  pBM_W  tree obm
itree_idx  in  1  tree osymb_m_idx
obm_val  out  1  step result valid
ibm_rdy  in  1  downstream ready
obm  out  pGRP_NUM*pBM_W  group g metric at bits [g*pBM_W +: pBM_W]
oidx  out  pGRP_NUM  bit g = selected pair index of group g
oerr  out  1  sticky protocol error

Behaviour:
- Reset (async, immediate): FSM=IDLE, issue and return counters=0, otree_val=0, ogrp=0, obm_val=0, obm=0, oidx=0, oerr=0, collection register=0. An in-flight step is discarded; results from the tree arriving after reset release are flagged as errors (see below).
- All registers update only on posedge iclk with iclkena=1. Handshakes count only when iclkena=1. The tree shares iclkena, so pTREE_LAT is in enabled cycles.
- FSM states:
  - IDLE: ostep_rdy=1. On accept, go to ISSUE with issue count=0.
  - ISSUE: otree_val=1, ogrp=issue count. Both are registered, so the first slot appears the cycle after accept. The count increments each enabled cycle. After slot pGRP_NUM-1, go to DRAIN.
  - DRAIN: otree_val=0. Wait until the return counter reaches pGRP_NUM.
  - XFER: the collection register moves to obm/oidx and obm_val is set when the output register is empty, or when obm_val & ibm_rdy in the same cycle. Otherwise the FSM stays in XFER.
  - After a transfer, go to IDLE.
- ostep_rdy=0 in every state except IDLE. Throughput is at most one step per pGRP_NUM+pTREE_LAT+2 enabled cycles.
- Collection:
  - Each itree_val stores itree_bm and itree_idx at slot = return counter, then the counter increments.
  - Results arrive in issue order, so no tag is needed.
  - The return counter clears on the transfer into the output register.
- Output register:
  - obm_val stays high until ibm_rdy.
  - obm/oidx are stable while obm_val=1 and ibm_rdy=0.
  - A pop and a transfer in the same cycle keep obm_val=1 and load the new data.
- oerr is set, and held until reset, on either event:
  - itree_val while in IDLE or XFER;
  - itree_val when the return counter already equals pGRP_NUM.
- Offending results are dropped.
- Latency: accept edge E0 gives the first otree_val in cycle E0+1. With the output register empty, obm_val rises pGRP_NUM+pTREE_LAT+1 enabled cycles after E0.
- An iclkena low during any state freezes the counters, otree_val and obm_val. Nothing is issued twice and nothing is lost.

Test Plan:
1. Defaults, single step: pulse istep_val. Tree model returns bm=10*g+1, idx=g[0]. -> otree_val for 4 cycles with ogrp 0,1,2,3. obm_val rises 8 cycles after accept. obm slots = 1,11,21,31. oidx=4'b1010. oerr=0.
2. Back-pressure: hold ibm_rdy=0 and issue two steps. -> Step 2 completes and waits in XFER with ostep_rdy=0. Raising ibm_rdy pops step 1 and loads step 2 in the same cycle, with obm_val continuously 1.
3. iclkena toggled 1,0,1,0 through a step. -> ogrp sequence 0,1,2,3 with each slot held while disabled. Exactly 4 results are captured, and obm matches case 1.
4. Spurious itree_val in IDLE. -> oerr=1 and sticky. obm/oidx unchanged. A following normal step still completes correctly.
5. Assert ireset during ISSUE at ogrp=2. -> otree_val, obm_val, ostep_rdy-state and counters reset immediately, with ostep_rdy=1 after release. Late tree results then set oerr.
6. Continuous istep_val with ibm_rdy=1. -> Accepts spaced exactly 9 cycles apart. obm_val is a 1-cycle pulse per step.
